prefix_tracker: RTL and testbench
=================================

# prefix_tracker

Parametrised instruction-prefix tracker for the x86 front end. It tracks segment-override, LOCK and REP/REPNE prefixes across the bytes of one instruction and drives the effective segment-register read select. It also keeps a small save stack so that a REP string instruction interrupted mid-way resumes with all of its prefixes, not just the last one. It sits between the prefix decoder and the segment register file, under microcode control.

## Interface
- NUM_SEGS, 4: number of segment registers; SEG_W = $clog2(NUM_SEGS), minimum 1.
- SS_INDEX, 2: segment index used for BP-based addressing.
- MAX_PREFIXES, 4: prefix bytes accepted per instruction; range 1..15.
- SAVE_DEPTH, 2: save-stack entries; range 1..4.

- clk  in  1  core clock.
- reset_n  in  1  reset, asynchronous, active low.
- next_instruction  in  1  instruction boundary; clears live state.
- flush  in  1  pipeline flush; clears live state, keeps save stack.
- update  in  1  a prefix byte is decoded this cycle.
- segment_override  in  1  with update: the byte is a segment override.
- override_in  in  SEG_W  override segment index.
- lock_prefix  in  1  with update: the byte is LOCK.
- rep_prefix  in  1  with update: the byte is REP/REPE.
- repne_prefix  in  1  with update: the byte is REPNE.
- force_segment  in  1  microcode forces its own select.
- bp_is_base  in  1  the addressing mode uses BP as base.
- microcode_sr_rd_sel  in  SEG_W  default segment select.
- string_suspend  in  1  pushes live state (REP string interrupted).
- string_resume  in  1  pops and restores saved state.
- sr_rd_sel  out  SEG_W  effective segment select (combinational).
- lock_active  out  1  LOCK is in effect.
- rep_active  out  1  a REP prefix is in effect.
- rep_ne  out  1  the REP kind is REPNE.
- prefix_count  out  4  prefix bytes accepted this instruction.
- prefix_overflow  out  1  one-cycle pulse: a prefix byte was rejected.
- save_overflow  out  1  one-cycle pulse: a push overwrote the full top entry.
- save_level  out  3  number of occupied stack entries.

## Operation
- Live state: override[SEG_W], override_active, lock, rep, repne, count.
- sr_rd_sel priority:
  1. force_segment → microcode_sr_rd_sel.
  2. update & segment_override & valid → override_in.
  3. override_active → override.
  4. bp_is_base → SS_INDEX.
  5. otherwise → microcode_sr_rd_sel.
- "valid" means override_in < NUM_SEGS. An invalid override is not captured and does not bypass, but it still counts as a prefix byte.
- An update with any prefix flag set and count < MAX_PREFIXES:
  - count increments.
  - A valid segment override replaces override and sets override_active. The last override wins.
  - lock_prefix sets lock.
  - rep_prefix sets rep and clears repne.
  - repne_prefix sets rep and repne.
  - If both rep_prefix and repne_prefix are set, repne_prefix wins.
- An update with count == MAX_PREFIXES: no state change, prefix_overflow pulses.
- An update with no prefix flag set is ignored.
- Save stack: a LIFO of SAVE_DEPTH entries, each holding live state without the count.
  - Push when full: overwrite the top entry and pulse save_overflow.
  - Pop when empty: no effect.
  - Only reset_n clears the stack.

## Timing
- On reset: all live state 0, stack empty, all registered outputs 0.
- sr_rd_sel is combinational; a same-cycle override bypasses the register.
- All other outputs are registered and reflect an update one cycle later.
- Per-cycle evaluation order:
  1. Push: snapshots the registered live state from the start of the cycle.
  2. Pop: loads live state and sets count to 0.
  3. Clear: next_instruction or flush zeroes live state, unless a pop occurred this cycle.
  4. Update: applied on top of the result.
- string_suspend and string_resume in the same cycle: the push happens, the resume is ignored.
- reset_n asserted mid-instruction: immediate asynchronous clear of everything.

## Structure
- Package prefix_pkg holds:
  - segment index constants SEG_ES=0, SEG_CS=1, SEG_SS=2, SEG_DS=3, SEG_FS=4, SEG_GS=5;
  - prefix_state_t, a struct of override, override_active, lock, rep, repne, parametrised through a SEG_W localparam;
  - MAX_PREFIX_LIMIT=15.
- Sub-module prefix_save_stack: a parametrised LIFO with push, pop, level and overflow pulse.
- prefix_tracker holds the live registers, the counter, the sr_rd_sel mux and the sequencing.

## Test plan
- Reset, then bp_is_base=1, microcode_sr_rd_sel=3 → sr_rd_sel=2, all outputs 0, save_level=0.
- update with override_in=0 (ES), then override_in=3 (DS), then next_instruction → sr_rd_sel=0 in the first cycle and 3 after the second; count=2; everything clears after next_instruction.
- MAX_PREFIXES=4: five prefix updates → count saturates at 4, prefix_overflow pulses on the 5th update only, state unchanged by the 5th.
- REP + ES override, string_suspend together with next_instruction, then flush ×3, then string_resume:
  - save_level = 1 then 0;
  - rep_active=1 and sr_rd_sel=0 restored;
  - count=0.
- SAVE_DEPTH=2: three suspends → save_overflow pulses on the 3rd; three resumes → the 3rd resume has no effect.
- NUM_SEGS=6 with override_in=7 → not captured, count increments, sr_rd_sel follows microcode.

Source files
------------

// File: rtl/prefix_pkg.sv
// Shared types and constants for the x86 instruction-prefix tracker.
// The override field is sized for up to 8 segment registers.
package prefix_pkg;

  localparam int SEG_ES = 0;
  localparam int SEG_CS = 1;
  localparam int SEG_SS = 2;
  localparam int SEG_DS = 3;
  localparam int SEG_FS = 4;
  localparam int SEG_GS = 5;

  localparam int SEG_W            = 3;
  localparam int MAX_PREFIX_LIMIT = 15;

  typedef struct packed {
    logic [SEG_W-1:0] override;
    logic             override_active;
    logic             lock;
    logic             rep;
    logic             repne;
  } prefix_state_t;

endpackage

// File: rtl/prefix_save_stack.sv
// LIFO of saved prefix states; push/pop take effect at the clock edge, level and overflow are registered.
// Never stalls: a push into a full stack overwrites the top entry and pulses overflow, a pop when empty is dropped.
module prefix_save_stack #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_dat,
  output logic [WIDTH-1:0] top_dat,
  output logic [2:0]       level,
  output logic             overflow
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             full;

  assign full = (level == 3'(DEPTH));

  always_comb begin
    top_dat = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (level == 3'(i + 1)) top_dat = mem[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      overflow <= push & full;
      if (push) begin
        for (int i = 0; i < DEPTH; i++) begin
          if ((!full && level == 3'(i)) || (full && i == DEPTH - 1)) mem[i] <= push_dat;
        end
        if (!full) level <= level + 3'd1;
      end else if (pop && level != 3'd0) begin
        level <= level - 3'd1;
      end
    end
  end

endmodule

// File: rtl/prefix_tracker.sv
// Tracks segment/LOCK/REP prefixes of one instruction; sr_rd_sel is combinational, all other outputs one cycle later.
// No backpressure: excess prefix bytes are dropped with a prefix_overflow pulse, save-stack overruns overwrite the top.
module prefix_tracker #(
  parameter int NUM_SEGS     = 4,
  parameter int SS_INDEX     = 2,
  parameter int MAX_PREFIXES = 4,
  parameter int SAVE_DEPTH   = 2,
  localparam int SEG_W       = (NUM_SEGS > 1) ? $clog2(NUM_SEGS) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             next_instruction,
  input  logic             flush,
  input  logic             update,
  input  logic             segment_override,
  input  logic [SEG_W-1:0] override_in,
  input  logic             lock_prefix,
  input  logic             rep_prefix,
  input  logic             repne_prefix,
  input  logic             force_segment,
  input  logic             bp_is_base,
  input  logic [SEG_W-1:0] microcode_sr_rd_sel,
  input  logic             string_suspend,
  input  logic             string_resume,
  output logic [SEG_W-1:0] sr_rd_sel,
  output logic             lock_active,
  output logic             rep_active,
  output logic             rep_ne,
  output logic [3:0]       prefix_count,
  output logic             prefix_overflow,
  output logic             save_overflow,
  output logic [2:0]       save_level
);

  import prefix_pkg::prefix_state_t;
  import prefix_pkg::MAX_PREFIX_LIMIT;

  localparam int MAXP = (MAX_PREFIXES > MAX_PREFIX_LIMIT) ? MAX_PREFIX_LIMIT : MAX_PREFIXES;
  localparam int SW   = $bits(prefix_state_t);

  prefix_state_t live_q, live_d;
  logic [3:0]    count_q, count_d;
  logic          povf_d;
  logic [SW-1:0] top_vec;
  logic          ovr_valid, any_flag, pop_eff;

  assign ovr_valid = (int'(override_in) < NUM_SEGS);
  assign any_flag  = segment_override | lock_prefix | rep_prefix | repne_prefix;
  // A resume alongside a suspend, or against an empty stack, is a no-op.
  assign pop_eff   = string_resume & ~string_suspend & (save_level != 3'd0);

  prefix_save_stack #(
    .DEPTH (SAVE_DEPTH),
    .WIDTH (SW)
  ) u_stack (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (string_suspend),
    .pop      (pop_eff),
    .push_dat (live_q),
    .top_dat  (top_vec),
    .level    (save_level),
    .overflow (save_overflow)
  );

  always_comb begin
    live_d  = live_q;
    count_d = count_q;
    povf_d  = 1'b0;
    if (pop_eff) begin
      live_d  = top_vec;
      count_d = '0;
    end else if (next_instruction || flush) begin
      live_d  = '0;
      count_d = '0;
    end
    if (update && any_flag) begin
      if (int'(count_d) < MAXP) begin
        count_d = count_d + 4'd1;
        if (segment_override && ovr_valid) begin
          live_d.override              = '0;
          live_d.override[SEG_W-1:0]   = override_in;
          live_d.override_active       = 1'b1;
        end
        if (lock_prefix) live_d.lock = 1'b1;
        if (repne_prefix) begin
          live_d.rep   = 1'b1;
          live_d.repne = 1'b1;
        end else if (rep_prefix) begin
          live_d.rep   = 1'b1;
          live_d.repne = 1'b0;
        end
      end else begin
        povf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      live_q          <= '0;
      count_q         <= '0;
      prefix_overflow <= 1'b0;
    end else begin
      live_q          <= live_d;
      count_q         <= count_d;
      prefix_overflow <= povf_d;
    end
  end

  always_comb begin
    if (force_segment)                                 sr_rd_sel = microcode_sr_rd_sel;
    else if (update && segment_override && ovr_valid)  sr_rd_sel = override_in;
    else if (live_q.override_active)                   sr_rd_sel = live_q.override[SEG_W-1:0];
    else if (bp_is_base)                               sr_rd_sel = SEG_W'(SS_INDEX);
    else                                               sr_rd_sel = microcode_sr_rd_sel;
  end

  assign lock_active  = live_q.lock;
  assign rep_active   = live_q.rep;
  assign rep_ne       = live_q.repne;
  assign prefix_count = count_q;

endmodule

// File: tb/tb_prefix_tracker.sv
// Self-checking bench for prefix_tracker: directed scenarios plus randomized traffic against a queue-based model.
module tb_prefix_tracker;

  localparam int NS    = 6;
  localparam int SSI   = 2;
  localparam int MAXP  = 4;
  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       next_instruction, flush, update, segment_override;
  logic [2:0] override_in, microcode_sr_rd_sel, sr_rd_sel;
  logic       lock_prefix, rep_prefix, repne_prefix, force_segment, bp_is_base;
  logic       string_suspend, string_resume;
  logic       lock_active, rep_active, rep_ne, prefix_overflow, save_overflow;
  logic [3:0] prefix_count;
  logic [2:0] save_level;
  logic [11:0] regs;

  int tests = 0;
  int fails = 0;

  typedef struct {int ovr; bit act; bit lock; bit rep; bit repne;} snap_t;
  snap_t m;
  snap_t stk[$];
  int    m_cnt;
  bit    m_povf, m_sovf;

  prefix_tracker #(
    .NUM_SEGS(NS), .SS_INDEX(SSI), .MAX_PREFIXES(MAXP), .SAVE_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .next_instruction(next_instruction), .flush(flush),
    .update(update), .segment_override(segment_override), .override_in(override_in),
    .lock_prefix(lock_prefix), .rep_prefix(rep_prefix), .repne_prefix(repne_prefix),
    .force_segment(force_segment), .bp_is_base(bp_is_base),
    .microcode_sr_rd_sel(microcode_sr_rd_sel), .string_suspend(string_suspend),
    .string_resume(string_resume), .sr_rd_sel(sr_rd_sel), .lock_active(lock_active),
    .rep_active(rep_active), .rep_ne(rep_ne), .prefix_count(prefix_count),
    .prefix_overflow(prefix_overflow), .save_overflow(save_overflow), .save_level(save_level)
  );

  always #5 clk = ~clk;

  assign regs = {lock_active, rep_active, rep_ne, prefix_count, prefix_overflow, save_overflow, save_level};

  function automatic int exp_sel();
    if (force_segment) return int'(microcode_sr_rd_sel);
    if (update && segment_override && int'(override_in) < NS) return int'(override_in);
    if (m.act) return m.ovr;
    if (bp_is_base) return SSI;
    return int'(microcode_sr_rd_sel);
  endfunction

  function automatic logic [11:0] exp_regs();
    return {m.lock, m.rep, m.repne, 4'(m_cnt), m_povf, m_sovf, 3'(stk.size())};
  endfunction

  task automatic model_reset();
    m = '{0, 0, 0, 0, 0};
    stk.delete();
    m_cnt = 0; m_povf = 0; m_sovf = 0;
  endtask

  task automatic model_step();
    snap_t cur = m;
    bit pop = string_resume && !string_suspend && stk.size() > 0;
    m_sovf = 0;
    if (string_suspend) begin
      if (stk.size() == DEPTH) begin stk[stk.size()-1] = cur; m_sovf = 1; end
      else stk.push_back(cur);
    end
    if (pop) begin m = stk.pop_back(); m_cnt = 0; end
    else if (next_instruction || flush) begin m = '{0, 0, 0, 0, 0}; m_cnt = 0; end
    m_povf = 0;
    if (update && (segment_override || lock_prefix || rep_prefix || repne_prefix)) begin
      if (m_cnt < MAXP) begin
        m_cnt++;
        if (segment_override && int'(override_in) < NS) begin m.ovr = int'(override_in); m.act = 1; end
        if (lock_prefix) m.lock = 1;
        if (repne_prefix) begin m.rep = 1; m.repne = 1; end
        else if (rep_prefix) begin m.rep = 1; m.repne = 0; end
      end else m_povf = 1;
    end
  endtask

  task automatic idle();
    next_instruction = 0; flush = 0; update = 0; segment_override = 0; override_in = 0;
    lock_prefix = 0; rep_prefix = 0; repne_prefix = 0; force_segment = 0;
    string_suspend = 0; string_resume = 0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk); #1;
    idle();
  endtask

  task automatic test_reset();
    idle(); bp_is_base = 1; microcode_sr_rd_sel = 3;
    reset_n = 0; model_reset();
    #2;
    tests++; if (sr_rd_sel !== 3'd2) begin fails++; $display("FAIL reset_sel got %0d exp 2", sr_rd_sel); end
    tests++; if (regs !== 12'd0) begin fails++; $display("FAIL reset_regs got %h exp 000", regs); end
    @(posedge clk); #1; reset_n = 1;
    tick();
    tests++; if (save_level !== 3'd0) begin fails++; $display("FAIL reset_level got %0d exp 0", save_level); end
  endtask

  task automatic test_override();
    bp_is_base = 0; microcode_sr_rd_sel = 1;
    update = 1; segment_override = 1; override_in = 0; #1;
    tests++; if (sr_rd_sel !== 3'd0) begin fails++; $display("FAIL ovr_bypass_es got %0d exp 0", sr_rd_sel); end
    tick();
    update = 1; segment_override = 1; override_in = 3; #1;
    tests++; if (sr_rd_sel !== 3'd3) begin fails++; $display("FAIL ovr_bypass_ds got %0d exp 3", sr_rd_sel); end
    tick(); #1;
    tests++; if (sr_rd_sel !== 3'd3) begin fails++; $display("FAIL ovr_held got %0d exp 3", sr_rd_sel); end
    tests++; if (prefix_count !== 4'd2) begin fails++; $display("FAIL ovr_count got %0d exp 2", prefix_count); end
    next_instruction = 1; tick(); #1;
    tests++; if (sr_rd_sel !== 3'd1) begin fails++; $display("FAIL ovr_cleared_sel got %0d exp 1", sr_rd_sel); end
    tests++; if (regs !== 12'd0) begin fails++; $display("FAIL ovr_cleared_regs got %h exp 000", regs); end
  endtask

  task automatic test_prefix_overflow();
    next_instruction = 1; tick();
    update = 1; lock_prefix = 1; tick();
    update = 1; rep_prefix = 1; tick();
    update = 1; segment_override = 1; override_in = 5; tick();
    update = 1; rep_prefix = 1; tick();
    tests++; if (prefix_count !== 4'd4 || prefix_overflow !== 1'b0) begin fails++;
      $display("FAIL povf_fill got cnt=%0d ovf=%0d exp cnt=4 ovf=0", prefix_count, prefix_overflow); end
    update = 1; repne_prefix = 1; segment_override = 1; override_in = 1; tick(); #1;
    tests++; if (prefix_overflow !== 1'b1) begin fails++; $display("FAIL povf_pulse got %0d exp 1", prefix_overflow); end
    tests++; if (prefix_count !== 4'd4 || rep_ne !== 1'b0 || rep_active !== 1'b1) begin fails++;
      $display("FAIL povf_state got cnt=%0d ne=%0d rep=%0d exp 4 0 1", prefix_count, rep_ne, rep_active); end
    tests++; if (sr_rd_sel !== 3'd5) begin fails++; $display("FAIL povf_sel got %0d exp 5", sr_rd_sel); end
    tick();
    tests++; if (prefix_overflow !== 1'b0) begin fails++; $display("FAIL povf_one_cycle got %0d exp 0", prefix_overflow); end
  endtask

  task automatic test_suspend_resume();
    microcode_sr_rd_sel = 3; bp_is_base = 0;
    next_instruction = 1; tick();
    update = 1; rep_prefix = 1; tick();
    update = 1; segment_override = 1; override_in = 0; tick();
    string_suspend = 1; next_instruction = 1; tick(); #1;
    tests++; if (save_level !== 3'd1 || rep_active !== 1'b0 || prefix_count !== 4'd0) begin fails++;
      $display("FAIL susp_push got lvl=%0d rep=%0d cnt=%0d exp 1 0 0", save_level, rep_active, prefix_count); end
    tests++; if (sr_rd_sel !== 3'd3) begin fails++; $display("FAIL susp_sel got %0d exp 3", sr_rd_sel); end
    repeat (3) begin flush = 1; tick(); end
    tests++; if (save_level !== 3'd1) begin fails++; $display("FAIL susp_flush_keeps got %0d exp 1", save_level); end
    string_resume = 1; tick(); #1;
    tests++; if (save_level !== 3'd0 || rep_active !== 1'b1 || prefix_count !== 4'd0) begin fails++;
      $display("FAIL resume_state got lvl=%0d rep=%0d cnt=%0d exp 0 1 0", save_level, rep_active, prefix_count); end
    tests++; if (sr_rd_sel !== 3'd0) begin fails++; $display("FAIL resume_sel got %0d exp 0", sr_rd_sel); end
  endtask

  task automatic test_save_overflow();
    next_instruction = 1; tick();
    update = 1; lock_prefix = 1; tick();
    string_suspend = 1; tick();
    update = 1; rep_prefix = 1; tick();
    string_suspend = 1; tick();
    tests++; if (save_level !== 3'd2 || save_overflow !== 1'b0) begin fails++;
      $display("FAIL sovf_fill got lvl=%0d ovf=%0d exp 2 0", save_level, save_overflow); end
    update = 1; segment_override = 1; override_in = 5; tick();
    string_suspend = 1; tick();
    tests++; if (save_overflow !== 1'b1 || save_level !== 3'd2) begin fails++;
      $display("FAIL sovf_pulse got ovf=%0d lvl=%0d exp 1 2", save_overflow, save_level); end
    next_instruction = 1; tick();
    tests++; if (save_overflow !== 1'b0) begin fails++; $display("FAIL sovf_one_cycle got %0d exp 0", save_overflow); end
    string_resume = 1; tick(); #1;
    tests++; if (sr_rd_sel !== 3'd5 || rep_active !== 1'b1 || lock_active !== 1'b1 || save_level !== 3'd1) begin fails++;
      $display("FAIL sovf_top_overwritten got sel=%0d rep=%0d lock=%0d lvl=%0d exp 5 1 1 1", sr_rd_sel, rep_active, lock_active, save_level); end
    string_resume = 1; tick();
    tests++; if (lock_active !== 1'b1 || rep_active !== 1'b0 || save_level !== 3'd0) begin fails++;
      $display("FAIL sovf_bottom got lock=%0d rep=%0d lvl=%0d exp 1 0 0", lock_active, rep_active, save_level); end
    update = 1; lock_prefix = 1; tick();
    string_resume = 1; tick();
    tests++; if (prefix_count !== 4'd1 || save_level !== 3'd0) begin fails++;
      $display("FAIL pop_empty got cnt=%0d lvl=%0d exp 1 0", prefix_count, save_level); end
  endtask

  task automatic test_invalid_override();
    bp_is_base = 0; microcode_sr_rd_sel = 4;
    next_instruction = 1; tick();
    update = 1; segment_override = 1; override_in = 7; #1;
    tests++; if (sr_rd_sel !== 3'd4) begin fails++; $display("FAIL inval_no_bypass got %0d exp 4", sr_rd_sel); end
    tick(); #1;
    tests++; if (prefix_count !== 4'd1 || sr_rd_sel !== 3'd4) begin fails++;
      $display("FAIL inval_counted got cnt=%0d sel=%0d exp 1 4", prefix_count, sr_rd_sel); end
    update = 1; segment_override = 1; override_in = 6; tick(); #1;
    tests++; if (prefix_count !== 4'd2 || sr_rd_sel !== 3'd4) begin fails++;
      $display("FAIL inval6 got cnt=%0d sel=%0d exp 2 4", prefix_count, sr_rd_sel); end
  endtask

  task automatic test_async_reset();
    update = 1; lock_prefix = 1; tick();
    string_suspend = 1; tick();
    @(negedge clk); reset_n = 0; #1;
    tests++; if (regs !== 12'd0) begin fails++; $display("FAIL async_reset got %h exp 000", regs); end
    model_reset();
    @(posedge clk); #1; reset_n = 1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      next_instruction = ($urandom_range(0, 9) == 0);
      flush            = ($urandom_range(0, 19) == 0);
      update           = ($urandom_range(0, 1) == 1);
      segment_override = ($urandom_range(0, 2) == 0);
      override_in      = 3'($urandom_range(0, 7));
      lock_prefix      = ($urandom_range(0, 3) == 0);
      rep_prefix       = ($urandom_range(0, 3) == 0);
      repne_prefix     = ($urandom_range(0, 3) == 0);
      force_segment    = ($urandom_range(0, 4) == 0);
      bp_is_base       = ($urandom_range(0, 1) == 1);
      microcode_sr_rd_sel = 3'($urandom_range(0, 7));
      string_suspend   = ($urandom_range(0, 7) == 0);
      string_resume    = ($urandom_range(0, 6) == 0);
      #1;
      tests++; if (int'(sr_rd_sel) !== exp_sel()) begin fails++;
        $display("FAIL rand_sel[%0d] got %0d exp %0d", i, sr_rd_sel, exp_sel()); end
      tick();
      tests++; if (regs !== exp_regs()) begin fails++;
        $display("FAIL rand_regs[%0d] got %h exp %h", i, regs, exp_regs()); end
    end
  endtask

  initial begin
    idle(); bp_is_base = 0; microcode_sr_rd_sel = 0;
    model_reset();
    test_reset();
    test_override();
    test_prefix_overflow();
    test_suspend_resume();
    test_save_overflow();
    test_invalid_override();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
